// File: rtl/axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// axi_write_arbiter : round-robin sharing of one AXI write-master core
//                     interface between two clients, grant held per transfer
// Revision: 1.0
// ============================================================================
module axi_write_arbiter #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  c0_write_request_valid,
    output logic                  c0_write_request_ready,
    input  logic [AXI_AWIDTH-1:0] c0_write_addr,
    input  logic [31:0]           c0_write_len,
    input  logic [2:0]            c0_write_size,
    input  logic [1:0]            c0_write_burst,
    input  logic [AXI_DWIDTH-1:0] c0_write_data,
    input  logic                  c0_write_data_valid,
    output logic                  c0_write_data_ready,

    input  logic                  c1_write_request_valid,
    output logic                  c1_write_request_ready,
    input  logic [AXI_AWIDTH-1:0] c1_write_addr,
    input  logic [31:0]           c1_write_len,
    input  logic [2:0]            c1_write_size,
    input  logic [1:0]            c1_write_burst,
    input  logic [AXI_DWIDTH-1:0] c1_write_data,
    input  logic                  c1_write_data_valid,
    output logic                  c1_write_data_ready,

    output logic                  m_write_request_valid,
    input  logic                  m_write_request_ready,
    output logic [AXI_AWIDTH-1:0] m_write_addr,
    output logic [31:0]           m_write_len,
    output logic [2:0]            m_write_size,
    output logic [1:0]            m_write_burst,
    output logic [AXI_DWIDTH-1:0] m_write_data,
    output logic                  m_write_data_valid,
    input  logic                  m_write_data_ready,

    output logic                  grant,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [31:0] beats_q, beats_d;

    logic        in_req, in_data;
    logic        sel_req_valid, sel_data_valid;
    logic        req_fire, data_fire;

    assign in_req  = (state_q == S_REQ);
    assign in_data = (state_q == S_DATA);

    // Fields always follow the owner; only the valids are gated by state.
    assign sel_req_valid  = grant_q ? c1_write_request_valid : c0_write_request_valid;
    assign sel_data_valid = grant_q ? c1_write_data_valid    : c0_write_data_valid;
    assign m_write_addr   = grant_q ? c1_write_addr  : c0_write_addr;
    assign m_write_len    = grant_q ? c1_write_len   : c0_write_len;
    assign m_write_size   = grant_q ? c1_write_size  : c0_write_size;
    assign m_write_burst  = grant_q ? c1_write_burst : c0_write_burst;
    assign m_write_data   = grant_q ? c1_write_data  : c0_write_data;

    assign m_write_request_valid = in_req  & sel_req_valid;
    assign m_write_data_valid    = in_data & sel_data_valid;

    assign c0_write_request_ready = in_req  & ~grant_q & m_write_request_ready;
    assign c1_write_request_ready = in_req  &  grant_q & m_write_request_ready;
    assign c0_write_data_ready    = in_data & ~grant_q & m_write_data_ready;
    assign c1_write_data_ready    = in_data &  grant_q & m_write_data_ready;

    assign req_fire  = m_write_request_valid & m_write_request_ready;
    assign data_fire = m_write_data_valid & m_write_data_ready;

    assign grant = grant_q;
    assign busy  = in_req | in_data;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beats_d = beats_q;
        case (state_q)
            S_IDLE: begin
                if (c0_write_request_valid || c1_write_request_valid) begin
                    // A tie goes to whoever was not served last.
                    if (c0_write_request_valid && c1_write_request_valid)
                        grant_d = ~last_q;
                    else
                        grant_d = c1_write_request_valid;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (req_fire) begin
                    beats_d = m_write_len;
                    last_d  = grant_q;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (data_fire) begin
                    if (beats_q == 32'd0)
                        state_d = S_IDLE;
                    else
                        beats_d = beats_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            beats_q <= 32'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axi_write_arbiter : directed + randomized transfers checked against a
//                        transaction-level round-robin model
// Revision: 1.0
// ============================================================================
module tb_axi_write_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          resetn;
    logic [1:0]    c_rv, c_rr, c_dv, c_dr;
    logic [AW-1:0] c_addr  [2];
    logic [31:0]   c_len   [2];
    logic [2:0]    c_size  [2];
    logic [1:0]    c_burst [2];
    logic [DW-1:0] c_data  [2];
    logic          m_rv, m_rr, m_dv, m_dr;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_len;
    logic [2:0]    m_size;
    logic [1:0]    m_burst;
    logic [DW-1:0] m_data;
    logic          gnt, busy;

    int            checks = 0;
    int            errors = 0;
    int            exp_last = 1;
    logic [1:0]    pend = 2'b00;
    logic [DW-1:0] base [2];

    always #5 clk = ~clk;

    axi_write_arbiter #(.AXI_AWIDTH(AW), .AXI_DWIDTH(DW)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .c0_write_request_valid (c_rv[0]),
        .c0_write_request_ready (c_rr[0]),
        .c0_write_addr          (c_addr[0]),
        .c0_write_len           (c_len[0]),
        .c0_write_size          (c_size[0]),
        .c0_write_burst         (c_burst[0]),
        .c0_write_data          (c_data[0]),
        .c0_write_data_valid    (c_dv[0]),
        .c0_write_data_ready    (c_dr[0]),
        .c1_write_request_valid (c_rv[1]),
        .c1_write_request_ready (c_rr[1]),
        .c1_write_addr          (c_addr[1]),
        .c1_write_len           (c_len[1]),
        .c1_write_size          (c_size[1]),
        .c1_write_burst         (c_burst[1]),
        .c1_write_data          (c_data[1]),
        .c1_write_data_valid    (c_dv[1]),
        .c1_write_data_ready    (c_dr[1]),
        .m_write_request_valid  (m_rv),
        .m_write_request_ready  (m_rr),
        .m_write_addr           (m_addr),
        .m_write_len            (m_len),
        .m_write_size           (m_size),
        .m_write_burst          (m_burst),
        .m_write_data           (m_data),
        .m_write_data_valid     (m_dv),
        .m_write_data_ready     (m_dr),
        .grant                  (gnt),
        .busy                   (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return 1 - last;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [1:0] onehot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input int n, input logic [AW-1:0] addr, input logic [31:0] len);
        c_addr[n]  = addr;
        c_len[n]   = len;
        c_size[n]  = 3'($urandom_range(0, 7));
        c_burst[n] = 2'($urandom_range(0, 2));
        base[n]    = $urandom;
        c_data[n]  = base[n];
    endtask

    task automatic check_all_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_m_rv"}, 64'(m_rv), 64'd0);
        chk({tag, "_m_dv"}, 64'(m_dv), 64'd0);
        chk({tag, "_c_rr"}, 64'(c_rr), 64'd0);
        chk({tag, "_c_dr"}, 64'(c_dr), 64'd0);
    endtask

    // One arbitration + transfer, starting in an IDLE cycle with >= 7 ns before the next edge.
    task automatic round(input bit r0, input bit r1, input int rq_wait, input int pat,
                         input bit early, input int abort_after);
        int     w;
        int     budget;
        longint cnt;
        w       = pick(r0, r1, exp_last);
        c_rv    = {r1, r0};
        pend    = {r1, r0};
        c_dv[w] = early;
        m_dr    = early;
        c_data[w] = base[w];
        #4;
        check_all_quiet("idle");
        next_cyc();
        for (int k = 0; k <= rq_wait; k++) begin
            m_rr = (k == rq_wait);
            #4;
            chk("req_busy",  64'(busy), 64'd1);
            chk("req_grant", 64'(gnt), 64'(w));
            chk("req_m_rv",  64'(m_rv), 64'd1);
            chk("req_addr",  64'(m_addr), 64'(c_addr[w]));
            chk("req_len",   64'(m_len), 64'(c_len[w]));
            chk("req_size",  64'(m_size), 64'(c_size[w]));
            chk("req_burst", 64'(m_burst), 64'(c_burst[w]));
            chk("req_c_rr",  64'(c_rr), m_rr ? 64'(onehot(w)) : 64'd0);
            chk("req_c_dr",  64'(c_dr), 64'd0);
            chk("req_m_dv",  64'(m_dv), 64'd0);
            next_cyc();
        end
        m_rr     = 1'b0;
        c_rv[w]  = 1'b0;
        pend[w]  = 1'b0;
        exp_last = w;
        cnt      = 0;
        budget   = 0;
        while (cnt <= longint'(c_len[w]) && (abort_after < 0 || cnt < longint'(abort_after))
               && budget < BUDGET) begin
            case (pat)
                0:       begin c_dv[w] = 1'b1; m_dr = 1'b1; end
                1:       begin c_dv[w] = 1'b1; m_dr = (budget % 2 == 0); end
                default: begin c_dv[w] = 1'($urandom_range(0, 1)); m_dr = 1'($urandom_range(0, 1)); end
            endcase
            c_data[w] = base[w] + cnt[31:0];
            #4;
            chk("dat_busy",  64'(busy), 64'd1);
            chk("dat_grant", 64'(gnt), 64'(w));
            chk("dat_m_rv",  64'(m_rv), 64'd0);
            chk("dat_c_rr",  64'(c_rr), 64'd0);
            chk("dat_m_dv",  64'(m_dv), 64'(c_dv[w]));
            chk("dat_c_dr",  64'(c_dr), m_dr ? 64'(onehot(w)) : 64'd0);
            chk("dat_data",  64'(m_data), 64'(base[w] + cnt[31:0]));
            if (c_dv[w] && m_dr) cnt++;
            budget++;
            next_cyc();
        end
        if (abort_after < 0) begin
            chk("beats_fired", 64'(cnt), 64'(longint'(c_len[w]) + 1));
            c_dv[w] = 1'b0;
            m_dr    = 1'b0;
            #2;
            check_all_quiet("done");
        end
    endtask

    // Asynchronous reset in the middle of a cycle while the owner still drives data.
    task automatic reset_mid(input int w);
        c_dv[w] = 1'b1;
        m_dr    = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check_all_quiet("rst");
        chk("rst_grant", 64'(gnt), 64'd0);
        c_dv = 2'b00;
        c_rv = 2'b00;
        m_dr = 1'b0;
        pend = 2'b00;
        exp_last = 1;
        next_cyc();
        resetn = 1'b1;
        next_cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        bit  r0, r1;
        resetn = 1'b0;
        c_rv = 2'b00; c_dv = 2'b00; m_rr = 1'b0; m_dr = 1'b0;
        for (int n = 0; n < 2; n++) set_txn(n, 32'h0, 32'd0);
        next_cyc();
        c_rv = 2'b11;
        m_rr = 1'b1;
        #4;
        check_all_quiet("reset");
        chk("reset_grant", 64'(gnt), 64'd0);
        c_rv = 2'b00;
        m_rr = 1'b0;
        next_cyc();
        resetn = 1'b1;
        next_cyc();

        // Tie after reset goes to c0, then c1, then alternation back to c0.
        set_txn(0, 32'h0000_2000, 32'd2);
        set_txn(1, 32'h0000_3000, 32'd1);
        round(1'b1, 1'b1, 0, 0, 1'b0, -1);
        round(1'b0, 1'b1, 1, 0, 1'b0, -1);
        set_txn(0, 32'h0000_2100, 32'd1);
        set_txn(1, 32'h0000_3100, 32'd7);
        round(1'b1, 1'b1, 0, 0, 1'b0, -1);
        // c1 still pending: toggled master back-pressure, 8 beats.
        round(1'b0, 1'b1, 0, 1, 1'b0, -1);

        // Single client.
        set_txn(0, 32'h0000_1000, 32'd3);
        round(1'b1, 1'b0, 0, 0, 1'b0, -1);

        // Single beat.
        set_txn(1, 32'h0000_4000, 32'd0);
        round(1'b0, 1'b1, 0, 0, 1'b0, -1);

        // Early data held off while the request waits 2 extra cycles.
        set_txn(0, 32'h0000_5000, 32'd2);
        round(1'b1, 1'b0, 2, 0, 1'b1, -1);

        for (int i = 0; i < 20; i++) begin
            r0 = pend[0];
            r1 = pend[1];
            if (!pend[0] && $urandom_range(0, 1) == 1) begin
                set_txn(0, $urandom, 32'($urandom_range(0, 6)));
                r0 = 1'b1;
            end
            if (!pend[1] && $urandom_range(0, 1) == 1) begin
                set_txn(1, $urandom, 32'($urandom_range(0, 6)));
                r1 = 1'b1;
            end
            if (!r0 && !r1) begin
                set_txn(i % 2, $urandom, 32'($urandom_range(0, 6)));
                if (i % 2 == 0) r0 = 1'b1; else r1 = 1'b1;
            end
            round(r0, r1, $urandom_range(0, 2), 2, 1'($urandom_range(0, 1)), -1);
        end
        // Drain any leftover pending request.
        if (pend[0] || pend[1])
            round(pend[0], pend[1], 0, 0, 1'b0, -1);

        // Reset after 2 of 5 beats, then c1 is served normally.
        set_txn(0, 32'h0000_6000, 32'd4);
        round(1'b1, 1'b0, 0, 0, 1'b0, 2);
        reset_mid(0);
        set_txn(1, 32'h0000_7000, 32'd4);
        round(1'b0, 1'b1, 0, 2, 1'b0, -1);

        // Maximum length: must still be busy after several beats.
        set_txn(0, 32'h0000_8000, 32'hFFFF_FFFF);
        round(1'b1, 1'b0, 0, 0, 1'b0, 6);
        #2;
        chk("maxlen_busy", 64'(busy), 64'd1);
        #1;
        reset_mid(0);
        w = pick(1'b1, 1'b1, exp_last);
        chk("post_reset_tie_model", 64'(w), 64'd0);
        set_txn(0, 32'h0000_9000, 32'd1);
        set_txn(1, 32'h0000_A000, 32'd2);
        round(1'b1, 1'b1, 0, 0, 1'b0, -1);
        round(1'b0, 1'b1, 0, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
